p_hit_feeder: RTL and testbench
===============================

Name: p_hit_feeder

Overview:
- Transmitter side of the p_hit input interface.
- Accepts one ray/triangle record per valid/ready handshake and fans it out to the four FIFO write lanes of p_hit (in_wr_en[3:0] / in_full[3:0]).
- Guarantees that every lane receives each record exactly once and in the same order across all lanes, so the internal empty-AND joins inside p_hit stay aligned.
- Sits between the BVH/triangle fetch stage and p_hit.

Parameters:
DATA_WIDTH, 32, width of each fixed-point component (Q16.16)
LOCKSTEP, 0, 1 = write all four lanes in the same cycle only; 0 = each lane writes independently as soon as it has space
CNT_WIDTH, 32, width of the issued-record and stall counters

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
in_tri_normal_1  input  3xDATA_WIDTH signed  triangle edge/normal term 1 [x,y,z]
in_tri_normal_2  input  3xDATA_WIDTH signed  triangle edge/normal term 2 [x,y,z]
in_v0  input  3xDATA_WIDTH signed  triangle vertex 0
in_origin  input  3xDATA_WIDTH signed  ray origin
in_dir  input  3xDATA_WIDTH signed  ray direction
in_valid  input  1  record on in_* is valid
in_ready  output  1  feeder accepts the record this cycle
tri_normal_1  output  3xDATA_WIDTH  lane 0 data
v0  output  3xDATA_WIDTH  lane 0 data
origin_1  output  3xDATA_WIDTH  lane 0 data
dir_1  output  3xDATA_WIDTH  lane 0 data
tri_normal_2  output  3xDATA_WIDTH  lane 1 data
dir_2  output  3xDATA_WIDTH  lane 2 data (copy of dir)
origin_2  output  3xDATA_WIDTH  lane 3 data (copy of origin)
p_hit_wr_en  output  4  per-lane write strobe to p_hit in_wr_en[3:0]
p_hit_full  input  4  per-lane full from p_hit in_full[3:0]
issued_count  output  CNT_WIDTH  number of records fully written to all lanes
stall_count  output  CNT_WIDTH  cycles with a pending lane blocked by full

Behaviour:
- Lane map is fixed:
  - lane 0 = {tri_normal_1, v0, origin_1, dir_1}
  - lane 1 = tri_normal_2
  - lane 2 = dir_2
  - lane 3 = origin_2
- All data outputs drive a single holding register. It is loaded on the handshake (in_valid && in_ready) and stays stable until every lane has been written.
- State: pending[3:0], where bit i = lane i has not yet been written for the held record. There is no separate FSM encoding: IDLE is pending==0, ISSUE is pending!=0.
- Write strobes:
  - LOCKSTEP=0: p_hit_wr_en[i] = pending[i] && !p_hit_full[i].
  - LOCKSTEP=1: p_hit_wr_en = pending when (pending & p_hit_full)==0, else 0.
- Each cycle, pending[i] clears when wr_en[i] is asserted.
- in_ready = (pending & ~p_hit_wr_en)==0, i.e. the holding register is empty or is being fully drained this cycle. This is combinational from p_hit_full and gives 1 record/clock when no lane is full.
- On handshake: holding register <= inputs, pending <= 4'b1111. This overrides the clear in the same cycle, so back-to-back records are allowed.
- Latency: a record accepted in cycle N has its first wr_en in cycle N+1 (registered data; strobes combinational from pending/full).
- issued_count increments by 1 in each cycle where pending!=0 and (pending & ~wr_en)==0. It wraps modulo 2^CNT_WIDTH.
- stall_count increments in each cycle where pending & p_hit_full != 0. It saturates at all-ones.
- Never assert wr_en[i] while p_hit_full[i]=1.
- Never write a lane twice for one record.
- in_valid with in_ready=0: the record is not captured. The upstream stage must hold it.
- Reset (reset=0), asynchronous, including mid-record:
  - pending=0, holding register=0, issued_count=0, stall_count=0.
  - Therefore p_hit_wr_en=0 and in_ready=1 immediately.
  - Any partially written record is dropped. The system resets p_hit at the same time, so lanes cannot desynchronise.
- All outputs after reset: data 0, p_hit_wr_en 4'b0000, in_ready 1, counters 0.

Test Plan:
- Single record (origin=(1.0,2.0,3.0) = 0x00010000,0x00020000,0x00030000), no fulls -> p_hit_wr_en=4'b1111 the cycle after accept; origin_1 and origin_2 both =0x00010000/0x00020000/0x00030000; issued_count=1.
- 8 back-to-back records, all full=0 -> in_ready stays 1; wr_en=4'b1111 for 8 consecutive cycles; issued_count=8; stall_count=0.
- LOCKSTEP=0, p_hit_full=4'b0100 held for 5 cycles after accept -> lanes 0,1,3 write in cycle 1, lane 2 writes in cycle 6; in_ready=0 in cycles 1-5; stall_count=5; issued_count=1.
- LOCKSTEP=1, same full pattern -> wr_en=0 for cycles 1-5, then 4'b1111 in cycle 6; stall_count=5.
- Random per-lane full (25% per lane), 1000 records -> each lane receives 1000 writes in identical order; no write while full; issued_count=1000.
- Assert reset low while pending=4'b0110 -> same cycle: wr_en=0, in_ready=1, counters=0; after release, a new record writes all four lanes once.

Source files
------------

// File: rtl/p_hit_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// p_hit_feeder : fans each ray/triangle record out to p_hit's four FIFO lanes
// Revision     : 1.0
// ---------------------------------------------------------------------------
module p_hit_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LOCKSTEP   = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [3*DATA_WIDTH-1:0] in_tri_normal_1,
  input  logic signed [3*DATA_WIDTH-1:0] in_tri_normal_2,
  input  logic signed [3*DATA_WIDTH-1:0] in_v0,
  input  logic signed [3*DATA_WIDTH-1:0] in_origin,
  input  logic signed [3*DATA_WIDTH-1:0] in_dir,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic        [3*DATA_WIDTH-1:0] tri_normal_1,
  output logic        [3*DATA_WIDTH-1:0] v0,
  output logic        [3*DATA_WIDTH-1:0] origin_1,
  output logic        [3*DATA_WIDTH-1:0] dir_1,
  output logic        [3*DATA_WIDTH-1:0] tri_normal_2,
  output logic        [3*DATA_WIDTH-1:0] dir_2,
  output logic        [3*DATA_WIDTH-1:0] origin_2,
  output logic        [3:0]              p_hit_wr_en,
  input  logic        [3:0]              p_hit_full,
  output logic        [CNT_WIDTH-1:0]    issued_count,
  output logic        [CNT_WIDTH-1:0]    stall_count
);

  localparam int VW = 3 * DATA_WIDTH;

  logic [VW-1:0]        tn1_q, tn2_q, v0_q, origin_q, dir_q;
  logic [3:0]           pending_q, pending_d;
  logic [3:0]           wr_en;
  logic [3:0]           left_over;
  logic                 accept;
  logic                 issue_done;
  logic                 stalled;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  // Lockstep waits until every pending lane has room, so all lanes move together.
  generate
    if (LOCKSTEP != 0) begin : g_lockstep
      assign wr_en = ((pending_q & p_hit_full) == 4'b0000) ? pending_q : 4'b0000;
    end else begin : g_independent
      assign wr_en = pending_q & ~p_hit_full;
    end
  endgenerate

  assign left_over  = pending_q & ~wr_en;
  assign in_ready   = (left_over == 4'b0000);
  assign accept     = in_valid && in_ready;
  assign issue_done = (pending_q != 4'b0000) && (left_over == 4'b0000);
  assign stalled    = ((pending_q & p_hit_full) != 4'b0000);

  always_comb begin
    pending_d = left_over;
    issued_d  = issued_q;
    stall_d   = stall_q;
    if (accept) begin
      pending_d = 4'b1111;
    end
    if (issue_done) begin
      issued_d = issued_q + 1'b1;
    end
    if (stalled && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= 4'b0000;
      issued_q  <= '0;
      stall_q   <= '0;
    end else begin
      pending_q <= pending_d;
      issued_q  <= issued_d;
      stall_q   <= stall_d;
    end
  end

  // Holding register: only loaded on a handshake, stable until fully drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tn1_q    <= '0;
      tn2_q    <= '0;
      v0_q     <= '0;
      origin_q <= '0;
      dir_q    <= '0;
    end else if (accept) begin
      tn1_q    <= in_tri_normal_1;
      tn2_q    <= in_tri_normal_2;
      v0_q     <= in_v0;
      origin_q <= in_origin;
      dir_q    <= in_dir;
    end
  end

  assign tri_normal_1 = tn1_q;
  assign v0           = v0_q;
  assign origin_1     = origin_q;
  assign dir_1        = dir_q;
  assign tri_normal_2 = tn2_q;
  assign dir_2        = dir_q;
  assign origin_2     = origin_q;
  assign p_hit_wr_en  = wr_en;
  assign issued_count = issued_q;
  assign stall_count  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_p_hit_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_p_hit_feeder : directed bench for p_hit_feeder (free-running and lockstep)
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_p_hit_feeder;

  localparam int DW = 32;
  localparam int VW = 3 * DW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [VW-1:0] tn1, tn2, vv0, org, dir;
  logic          valid0 = 1'b0, valid1 = 1'b0;
  logic [3:0]    full = 4'b0000;

  logic          ready0, ready1;
  logic [VW-1:0] tn1_0, v0_0, org1_0, dir1_0, tn2_0, dir2_0, org2_0;
  logic [VW-1:0] tn1_1, v0_1, org1_1, dir1_1, tn2_1, dir2_1, org2_1;
  logic [3:0]    wr0, wr1;
  logic [31:0]   iss0, iss1, stl0, stl1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  p_hit_feeder #(.DATA_WIDTH(DW), .LOCKSTEP(0), .CNT_WIDTH(32)) u_free (
    .clock(clock), .reset(reset),
    .in_tri_normal_1(tn1), .in_tri_normal_2(tn2), .in_v0(vv0),
    .in_origin(org), .in_dir(dir), .in_valid(valid0), .in_ready(ready0),
    .tri_normal_1(tn1_0), .v0(v0_0), .origin_1(org1_0), .dir_1(dir1_0),
    .tri_normal_2(tn2_0), .dir_2(dir2_0), .origin_2(org2_0),
    .p_hit_wr_en(wr0), .p_hit_full(full),
    .issued_count(iss0), .stall_count(stl0)
  );

  p_hit_feeder #(.DATA_WIDTH(DW), .LOCKSTEP(1), .CNT_WIDTH(32)) u_lock (
    .clock(clock), .reset(reset),
    .in_tri_normal_1(tn1), .in_tri_normal_2(tn2), .in_v0(vv0),
    .in_origin(org), .in_dir(dir), .in_valid(valid1), .in_ready(ready1),
    .tri_normal_1(tn1_1), .v0(v0_1), .origin_1(org1_1), .dir_1(dir1_1),
    .tri_normal_2(tn2_1), .dir_2(dir2_1), .origin_2(org2_1),
    .p_hit_wr_en(wr1), .p_hit_full(full),
    .issued_count(iss1), .stall_count(stl1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_rec(input logic [31:0] k);
    tn1 = {k + 32'h100, k + 32'h101, k + 32'h102};
    tn2 = {k + 32'h200, k + 32'h201, k + 32'h202};
    vv0 = {k + 32'h300, k + 32'h301, k + 32'h302};
    org = {k + 32'h400, k + 32'h401, k + 32'h402};
    dir = {k + 32'h500, k + 32'h501, k + 32'h502};
  endtask

  initial begin
    int lane_cnt [4];
    int sent, cycles, full_writes, order_errs;
    logic [31:0] lane_val [4];

    tn1 = '0; tn2 = '0; vv0 = '0; org = '0; dir = '0;
    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_wr_free", wr0, 4'b0000);
    chk("rst_wr_lock", wr1, 4'b0000);
    chk("rst_ready", {ready0, ready1}, 2'b11);
    chk("rst_counters", {iss0, stl0, iss1, stl1}, 128'd0);
    chk("rst_data", org1_0 | org2_0 | tn1_0 | dir2_1, 96'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Single record with origin (1.0, 2.0, 3.0)
    set_rec(32'd0);
    org = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    valid0 = 1'b1; valid1 = 1'b1;
    #1;
    chk("single_ready", {ready0, ready1}, 2'b11);
    tick();
    valid0 = 1'b0; valid1 = 1'b0;
    #1;
    chk("single_wr_free", wr0, 4'b1111);
    chk("single_wr_lock", wr1, 4'b1111);
    chk("single_origin_1", org1_0, {32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
    chk("single_origin_2", org2_0, {32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
    chk("single_tn1", tn1_0, {32'h100, 32'h101, 32'h102});
    chk("single_tn2", tn2_0, {32'h200, 32'h201, 32'h202});
    chk("single_v0", v0_0, {32'h300, 32'h301, 32'h302});
    chk("single_dir2", dir2_1, {32'h500, 32'h501, 32'h502});
    tick();
    chk("single_issued", {iss0, iss1}, {32'd1, 32'd1});
    chk("single_idle_wr", {wr0, wr1}, 8'h00);

    // 8 back-to-back records
    for (int k = 1; k <= 8; k++) begin
      set_rec(32'(k * 16));
      valid0 = 1'b1; valid1 = 1'b1;
      #1;
      chk("b2b_ready", {ready0, ready1}, 2'b11);
      if (k > 1) begin
        chk("b2b_wr", {wr0, wr1}, 8'hFF);
        chk("b2b_origin", org1_0, {32'((k - 1) * 16 + 32'h400), 32'((k - 1) * 16 + 32'h401),
                                   32'((k - 1) * 16 + 32'h402)});
      end
      tick();
    end
    valid0 = 1'b0; valid1 = 1'b0;
    #1;
    chk("b2b_wr_last", {wr0, wr1}, 8'hFF);
    chk("b2b_dir1_last", dir1_1, {32'h580, 32'h581, 32'h582});
    tick();
    chk("b2b_issued", {iss0, iss1}, {32'd9, 32'd9});
    chk("b2b_stall", {stl0, stl1}, 64'd0);

    // Lane 2 full for five cycles after accept
    set_rec(32'h1000);
    valid0 = 1'b1; valid1 = 1'b1;
    full = 4'b0100;
    #1;
    chk("full_accept_ready", {ready0, ready1}, 2'b11);
    tick();
    valid0 = 1'b0; valid1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("full_wr_free", wr0, (c == 1) ? 4'b1011 : 4'b0000);
      chk("full_wr_lock", wr1, 4'b0000);
      chk("full_ready", {ready0, ready1}, 2'b00);
      tick();
    end
    full = 4'b0000;
    #1;
    chk("full_c6_wr_free", wr0, 4'b0100);
    chk("full_c6_wr_lock", wr1, 4'b1111);
    chk("full_c6_ready", {ready0, ready1}, 2'b11);
    chk("full_c6_dir2", dir2_0, {32'h1500, 32'h1501, 32'h1502});
    tick();
    chk("full_stall", {stl0, stl1}, {32'd5, 32'd5});
    chk("full_issued", {iss0, iss1}, {32'd10, 32'd10});

    // Random 25% per-lane full, 1000 records through the free-running instance
    for (int l = 0; l < 4; l++) lane_cnt[l] = 0;
    sent = 0; cycles = 0; full_writes = 0; order_errs = 0;
    while ((lane_cnt[0] < 1000 || lane_cnt[1] < 1000 || lane_cnt[2] < 1000 ||
            lane_cnt[3] < 1000) && cycles < 20000) begin
      for (int b = 0; b < 4; b++) full[b] = ($urandom_range(3) == 0);
      valid0 = (sent < 1000);
      tn1 = {3{32'(sent)}}; tn2 = {3{32'(sent)}}; vv0 = {3{32'(sent)}};
      org = {3{32'(sent)}}; dir = {3{32'(sent)}};
      #1;
      if ((wr0 & full) != 4'b0000) full_writes++;
      lane_val[0] = org1_0[31:0];
      lane_val[1] = tn2_0[31:0];
      lane_val[2] = dir2_0[31:0];
      lane_val[3] = org2_0[31:0];
      if (wr0[0] && (tn1_0[95:64] != lane_val[0] || v0_0[63:32] != lane_val[0] ||
                     dir1_0[31:0] != lane_val[0])) order_errs++;
      for (int l = 0; l < 4; l++) begin
        if (wr0[l]) begin
          if (lane_val[l] != 32'(lane_cnt[l])) order_errs++;
          lane_cnt[l]++;
        end
      end
      if (valid0 && ready0) sent++;
      cycles++;
      tick();
    end
    valid0 = 1'b0;
    full = 4'b0000;
    #1;
    chk("rand_no_timeout", cycles < 20000, 1'b1);
    chk("rand_lane0", lane_cnt[0], 1000);
    chk("rand_lane1", lane_cnt[1], 1000);
    chk("rand_lane2", lane_cnt[2], 1000);
    chk("rand_lane3", lane_cnt[3], 1000);
    chk("rand_order", order_errs, 0);
    chk("rand_write_while_full", full_writes, 0);
    chk("rand_issued", iss0, 32'd1010);

    // Reset asserted while lanes 1 and 2 are still pending
    set_rec(32'h2000);
    valid0 = 1'b1;
    full = 4'b0110;
    tick();
    valid0 = 1'b0;
    #1;
    chk("mid_wr_first", wr0, 4'b1001);
    tick();
    #1;
    chk("mid_held_wr", wr0, 4'b0000);
    chk("mid_held_ready", ready0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr", {wr0, wr1}, 8'h00);
    chk("mid_rst_ready", {ready0, ready1}, 2'b11);
    chk("mid_rst_counters", {iss0, stl0, iss1, stl1}, 128'd0);
    tick();
    reset = 1'b1;
    full = 4'b0000;
    set_rec(32'h3000);
    valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    #1;
    chk("post_rst_wr", wr0, 4'b1111);
    chk("post_rst_origin2", org2_0, {32'h3400, 32'h3401, 32'h3402});
    tick();
    chk("post_rst_wr_once", wr0, 4'b0000);
    chk("post_rst_issued", iss0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
